sdram_cpu_port: RTL and testbench
=================================

Name: sdram_cpu_port

Overview:
- Request front-end for the CPU side of the NES SDRAM slot controller.
- Accepts CPU-domain read/write requests on a valid/ready handshake and buffers them in a small FIFO.
- Generates the slot-alignment `sync` pulse and tracks the 24-cycle slot phase.
- Issues at most one buffered request per slot on the controller's `cpu_*` pins, captures read data at its fixed slot cycle, and returns it on a response strobe in request order.

Parameters:
- ADDR_DEPTH, 23: address width; matches the controller's per-bank address width.
- FIFO_DEPTH, 4: request FIFO entries; power of 2, at least 2.
- SLOT_LEN, 24: slot period in clocks.
- ISSUE_PHASE, 23: phase in which the controller latches `cpu_*` inputs.
- RDATA_PHASE, 8: phase in which `cpu_data_rd` is valid for a read issued in the previous ISSUE_PHASE.

Ports:
- clk  in  1  clock; the controller's clock.
- rst  in  1  reset, synchronous, active-high.
- ctrl_rdy  in  1  controller ready; it is in its main loop.
- sync_out  out  1  one-cycle slot alignment pulse to the controller's `sync`.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_DEPTH  request address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  8  read data; held until the next response.
- cpu_addr  out  ADDR_DEPTH  to controller.
- cpu_data_wr  out  8  to controller.
- cpu_rd  out  1  to controller.
- cpu_wr  out  1  to controller.
- cpu_data_rd  in  8  from controller.

Behaviour:
- Reset values: all outputs 0; FIFO empty; phase 0; in-flight flag cleared; state SYNC.
- Reset mid-operation flushes the FIFO and drops any in-flight read; no response is generated for it.
- State machine:
  - SYNC: sync_out=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold until ctrl_rdy=1, then go to RUN.
  - RUN: if ctrl_rdy falls, return to WAIT. The FIFO is kept; any in-flight read still completes.
- Phase counter:
  - At the edge where sync_out=1, phase <= ISSUE_PHASE.
  - Otherwise phase increments each clock and wraps SLOT_LEN-1 -> 0.
  - The phase therefore equals the controller's internal slot counter at all times after sync.
- Acceptance:
  - req_ready = (state != SYNC) && FIFO not full. It is combinational from registered state.
  - Requests may be accepted in WAIT. No bypass: a full FIFO refuses even on the cycle a pop occurs.
- Issue:
  - Occurs at the edge entering phase ISSUE_PHASE, in RUN, with the FIFO non-empty.
  - Pop the head onto cpu_addr/cpu_data_wr and set cpu_rd = !we, cpu_wr = we.
  - Outputs are held stable for the full slot, until the next entry to ISSUE_PHASE.
  - At that next entry, either load the next entry or drive cpu_rd = cpu_wr = 0; address/data are held.
  - An empty FIFO at issue yields an idle slot.
- Read return:
  - A read issue sets the in-flight flag.
  - At the edge ending phase RDATA_PHASE with the flag set: rsp_rdata <= cpu_data_rd, rsp_valid <= 1 for one cycle, flag cleared.
- Latency: from acceptance into an empty FIFO, issue occurs at the next ISSUE_PHASE entry. rsp_valid follows issue by RDATA_PHASE+2 clocks (10 at defaults).
- Ordering and throughput: responses come in issue order; at most one issue per slot; no back-pressure on rsp.
- Simultaneous push and pop in the same cycle are both performed; the count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; the count is clog2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
- SDRAM_CPU_PORT_WRITE_ACK_EN defined: a write issue also sets the in-flight flag (with a write marker).
  - At RDATA_PHASE, rsp_valid pulses and rsp_rdata is left unchanged.
  - Every accepted request thus gets exactly one response.
- Undefined: writes produce no response.

Test Plan:
- Reset release: sync_out high for exactly 1 cycle, then 0.
  - cpu_rd and cpu_wr stay 0 while ctrl_rdy=0.
  - Phase is 23 on the cycle after sync_out.
- Single read of addr 0x000123, with the controller model returning 0x5A at phase 8:
  - cpu_rd=1 and cpu_addr=0x000123 during phases 23..22.
  - rsp_valid pulses once 10 clocks after issue, rsp_rdata=0x5A.
- Write 0xA5 to 0x7FFFFF followed by a read of the same address:
  - Write issued in slot N (cpu_wr=1, cpu_data_wr=0xA5); read issued in slot N+1.
  - One response (0xA5) without the macro; two responses with it.
- Burst of 6 back-to-back requests with FIFO_DEPTH=4, issued before phase 23:
  - req_ready drops after 4 are accepted and reasserts the cycle after the first pop.
  - All 6 are issued in 6 consecutive slots, in order.
- ctrl_rdy drops mid-slot with 2 requests queued:
  - No further issues; the in-flight read still returns.
  - Queued requests issue after ctrl_rdy returns.
- rst asserted in the cycle after a read issue:
  - No rsp_valid; FIFO empty; sync_out re-pulses after release.

Source files
------------

// File: rtl/sdram_cpu_port.sv
// CPU-side request front-end for the NES SDRAM slot controller: buffers requests,
// aligns to the 24-cycle slot, issues one per slot. Define SDRAM_CPU_PORT_WRITE_ACK_EN to ack writes.
module sdram_cpu_port #(
    parameter int unsigned ADDR_DEPTH  = 23,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SLOT_LEN    = 24,
    parameter int unsigned ISSUE_PHASE = 23,
    parameter int unsigned RDATA_PHASE = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_rdy,
    output logic                  sync_out,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_DEPTH-1:0] req_addr,
    input  logic [7:0]            req_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic [ADDR_DEPTH-1:0] cpu_addr,
    output logic [7:0]            cpu_data_wr,
    output logic                  cpu_rd,
    output logic                  cpu_wr,
    input  logic [7:0]            cpu_data_rd
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned PHASE_W   = $clog2(SLOT_LEN);
    localparam int unsigned PRE_ISSUE = (ISSUE_PHASE == 0) ? SLOT_LEN - 1 : ISSUE_PHASE - 1;

    localparam logic [PHASE_W-1:0] PH_ISSUE     = PHASE_W'(ISSUE_PHASE);
    localparam logic [PHASE_W-1:0] PH_PRE_ISSUE = PHASE_W'(PRE_ISSUE);
    localparam logic [PHASE_W-1:0] PH_RDATA     = PHASE_W'(RDATA_PHASE);
    localparam logic [PHASE_W-1:0] PH_LAST      = PHASE_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StSync, StWait, StRun} state_e;

    state_e              state_q, state_d;
    logic                sync_q, sync_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;

    logic                  fifo_we_q    [FIFO_DEPTH];
    logic [ADDR_DEPTH-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [7:0]            fifo_wdata_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  cpu_rd_q, cpu_wr_q;
    logic [ADDR_DEPTH-1:0] cpu_addr_q;
    logic [7:0]            cpu_data_wr_q;
    logic                  inflight_q, inflight_wr_q;
    logic                  rsp_valid_q;
    logic [7:0]            rsp_rdata_q;

    logic fifo_full, fifo_empty, push, pop, issue_entry, rdata_exit, head_we;

    assign fifo_full   = (count_q == CNT_FULL);
    assign fifo_empty  = (count_q == '0);
    assign req_ready   = (state_q != StSync) && !fifo_full;
    assign push        = req_valid && req_ready;
    // The sync edge reloads the phase, so it never counts as a natural issue entry.
    assign issue_entry = !sync_q && (phase_q == PH_PRE_ISSUE);
    assign rdata_exit  = (phase_q == PH_RDATA);
    assign pop         = issue_entry && (state_q == StRun) && !fifo_empty;
    assign head_we     = fifo_we_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        sync_d  = 1'b0;
        case (state_q)
            StSync: begin
                if (!sync_q) begin
                    sync_d = 1'b1;
                end else begin
                    state_d = StWait;
                end
            end
            StWait:  if (ctrl_rdy) state_d = StRun;
            StRun:   if (!ctrl_rdy) state_d = StWait;
            default: state_d = StSync;
        endcase
    end

    always_comb begin
        if (sync_q) begin
            phase_d = PH_ISSUE;
        end else if (phase_q == PH_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StSync;
            sync_q   <= 1'b0;
            phase_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            phase_q <= phase_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we_q[wr_ptr_q]    <= req_we;
            fifo_addr_q[wr_ptr_q]  <= req_addr;
            fifo_wdata_q[wr_ptr_q] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rd_q      <= 1'b0;
            cpu_wr_q      <= 1'b0;
            cpu_addr_q    <= '0;
            cpu_data_wr_q <= '0;
            inflight_q    <= 1'b0;
            inflight_wr_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (rdata_exit && inflight_q) begin
                rsp_valid_q <= 1'b1;
                inflight_q  <= 1'b0;
                if (!inflight_wr_q) rsp_rdata_q <= cpu_data_rd;
            end
            // Command strobes last exactly one slot; address and data stay put when idle.
            if (issue_entry) begin
                cpu_rd_q <= 1'b0;
                cpu_wr_q <= 1'b0;
                if (pop) begin
                    cpu_addr_q    <= fifo_addr_q[rd_ptr_q];
                    cpu_data_wr_q <= fifo_wdata_q[rd_ptr_q];
                    cpu_rd_q      <= !head_we;
                    cpu_wr_q      <= head_we;
`ifdef SDRAM_CPU_PORT_WRITE_ACK_EN
                    inflight_q    <= 1'b1;
                    inflight_wr_q <= head_we;
`else
                    inflight_wr_q <= 1'b0;
                    if (!head_we) inflight_q <= 1'b1;
`endif
                end
            end
        end
    end

    assign sync_out    = sync_q;
    assign cpu_rd      = cpu_rd_q;
    assign cpu_wr      = cpu_wr_q;
    assign cpu_addr    = cpu_addr_q;
    assign cpu_data_wr = cpu_data_wr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_sdram_cpu_port.sv
// Scoreboard bench for sdram_cpu_port: slot-level reference model, controller memory model,
// directed scenarios followed by randomized traffic.
module tb_sdram_cpu_port;

    localparam int AW   = 23;
    localparam int FD   = 4;
    localparam int SLOT = 24;
    localparam int ISS  = 23;
    localparam int RDP  = 8;
    localparam int HALF = 5;

    logic          clk = 1'b0;
    logic          rst, ctrl_rdy, sync_out;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_wdata;
    logic          rsp_valid;
    logic [7:0]    rsp_rdata;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_data_wr;
    logic          cpu_rd, cpu_wr;
    logic [7:0]    cpu_data_rd;

    sdram_cpu_port dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_rdy   (ctrl_rdy),
        .sync_out   (sync_out),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .cpu_addr   (cpu_addr),
        .cpu_data_wr(cpu_data_wr),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_data_rd(cpu_data_rd)
    );

    always #HALF clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        time           t;
    } req_t;

    typedef struct {
        logic       wr;
        logic [7:0] data;
    } rsp_t;

    req_t       issue_q[$];
    rsp_t       exp_q[$];
    logic [7:0] ref_mem[int];
    logic [7:0] cmem[int];
    int         checks = 0;
    int         errors = 0;
    int         issue_cnt = 0;
    int         sync_cnt = 0;

    function automatic logic [7:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hC3 ^ {a[10:8], 5'b0};
    endfunction

    function automatic logic [7:0] ref_rd(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    function automatic logic [7:0] cmem_rd(input logic [AW-1:0] a);
        if (cmem.exists(int'(a))) return cmem[int'(a)];
        return init_val(a);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: slot-level model of the edge just passed, controller model, response scoreboard.
    initial begin : monitor
        int            k;
        int            phase;
        bit            run_prev, run_before, saved_rst, saved_rdy, rst_e, rdy_e;
        bit            inflight_m, exp_sync, exp_rsp, lat_rd;
        logic          e_rd, e_wr;
        logic [AW-1:0] e_addr, lat_addr;
        logic [7:0]    e_wdata, last_rdata;
        req_t          h;
        rsp_t          r;
        k = 0; phase = 0; run_prev = 0; saved_rst = 1; saved_rdy = 0; inflight_m = 0;
        lat_rd = 0; lat_addr = '0; e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
        last_rdata = '0;
        cpu_data_rd = '0;
        forever begin
            @(negedge clk);
            rst_e    = saved_rst;
            rdy_e    = saved_rdy;
            exp_sync = 0;
            exp_rsp  = 0;
            if (rst_e) begin
                k = 0; phase = 0; run_prev = 0; inflight_m = 0; lat_rd = 0;
                e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0; last_rdata = '0;
                issue_q.delete();
                exp_q.delete();
            end else begin
                run_before = run_prev;
                k++;
                if (k == 1) exp_sync = 1;
                if (k == 2) phase = ISS;
                else if (k > 2) phase = (phase + 1) % SLOT;
                run_prev = (k >= 3) && rdy_e;
                if (k > 2 && phase == RDP + 1 && inflight_m) begin
                    exp_rsp    = 1;
                    inflight_m = 0;
                end
                if (k > 2 && phase == ISS) begin
                    e_rd = 0;
                    e_wr = 0;
                    if (run_before && issue_q.size() > 0 && issue_q[0].t < $time - HALF) begin
                        h       = issue_q.pop_front();
                        e_addr  = h.addr;
                        e_wdata = h.data;
                        e_rd    = !h.we;
                        e_wr    = h.we;
                        issue_cnt++;
`ifdef SDRAM_CPU_PORT_WRITE_ACK_EN
                        inflight_m = 1;
`else
                        if (!h.we) inflight_m = 1;
`endif
                    end
                    lat_rd   = cpu_rd;
                    lat_addr = cpu_addr;
                    if (cpu_wr) cmem[int'(cpu_addr)] = cpu_data_wr;
                end
            end
            chk("sync_out", 32'(sync_out), 32'(exp_sync));
            chk("cpu_rd", 32'(cpu_rd), 32'(e_rd));
            chk("cpu_wr", 32'(cpu_wr), 32'(e_wr));
            chk("cpu_addr", 32'(cpu_addr), 32'(e_addr));
            chk("cpu_data_wr", 32'(cpu_data_wr), 32'(e_wdata));
            chk("req_ready", 32'(req_ready), 32'(!rst_e && k >= 2 && issue_q.size() < FD));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            if (rst_e) chk("rsp_rdata_reset", 32'(rsp_rdata), 32'h0);
            if (sync_out) sync_cnt++;
            if (rsp_valid) begin
                chk("rsp_expected", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    if (!r.wr) begin
                        chk("rsp_rdata", 32'(rsp_rdata), 32'(r.data));
                        last_rdata = r.data;
                    end else begin
                        chk("rsp_rdata_held", 32'(rsp_rdata), 32'(last_rdata));
                    end
                end
            end
            if (k > 2 && phase == RDP && lat_rd) cpu_data_rd = cmem_rd(lat_addr);
            else cpu_data_rd = 8'($urandom);
            saved_rst = rst;
            saved_rdy = ctrl_rdy;
        end
    end

    // All stimulus tasks start and end at posedge+2.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [7:0] d);
        bit   acc;
        bit   rdy_s;
        int   budget;
        rsp_t r;
        acc    = 0;
        budget = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = d;
        while (!acc && budget < 400) begin
            #1;
            rdy_s = req_ready;
            @(posedge clk);
            if (rdy_s) begin
                acc = 1;
                issue_q.push_back('{we: we, addr: addr, data: d, t: $time});
                if (we) begin
                    ref_mem[int'(addr)] = d;
`ifdef SDRAM_CPU_PORT_WRITE_ACK_EN
                    r.wr = 1'b1;
                    r.data = 8'h00;
                    exp_q.push_back(r);
`endif
                end else begin
                    r.wr   = 1'b0;
                    r.data = ref_rd(addr);
                    exp_q.push_back(r);
                end
            end
            budget++;
            #2;
        end
        req_valid = 1'b0;
        chk("req_accepted", 32'(acc), 32'h1);
    endtask

    task automatic drain(input int limit);
        int b;
        b = 0;
        while ((issue_q.size() > 0 || exp_q.size() > 0) && b < limit) begin
            idle(1);
            b++;
        end
        chk("pending_after_drain", 32'(issue_q.size() + exp_q.size()), 32'h0);
        idle(4);
    endtask

    task automatic wait_issue();
        int n;
        int b;
        n = issue_cnt;
        b = 0;
        while (issue_cnt == n && b < 200) begin
            idle(1);
            b++;
        end
        chk("issue_seen", 32'(issue_cnt > n), 32'h1);
    endtask

    initial begin : stimulus
        int            s0;
        logic [AW-1:0] a;
        rst = 1'b1; ctrl_rdy = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0;
        ref_mem[32'h123] = 8'h5A;
        cmem[32'h123]    = 8'h5A;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Controller idle: one sync pulse, no commands.
        idle(40);
        chk("sync_pulses", 32'(sync_cnt), 32'h1);

        ctrl_rdy = 1'b1;
        send(1'b0, 23'h000123, 8'h00);
        drain(300);

        send(1'b1, 23'h7FFFFF, 8'hA5);
        send(1'b0, 23'h7FFFFF, 8'h00);
        drain(300);

        for (int i = 0; i < 6; i++) begin
            send(1'($urandom), AW'($urandom_range(0, 15)), 8'($urandom));
        end
        drain(400);

        // ctrl_rdy drops mid-slot with one read in flight and two queued.
        for (int i = 0; i < 3; i++) send(1'b0, AW'(32 + i), 8'h00);
        wait_issue();
        idle(3);
        ctrl_rdy = 1'b0;
        idle(60);
        chk("queued_while_not_ready", 32'(issue_q.size()), 32'h2);
        ctrl_rdy = 1'b1;
        drain(300);

        // Reset just after a read issues: its response must vanish.
        send(1'b0, 23'h000055, 8'h00);
        wait_issue();
        rst = 1'b1;
        idle(2);
        s0  = sync_cnt;
        rst = 1'b0;
        idle(40);
        chk("resync_pulses", 32'(sync_cnt - s0), 32'h1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                ctrl_rdy = 1'b0;
                idle($urandom_range(5, 40));
                ctrl_rdy = 1'b1;
            end
            idle($urandom_range(0, 30));
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            send(1'($urandom), a, 8'($urandom));
        end
        drain(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=%0t required=<500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
